// File: rtl/mc_control_fsm_pkg.sv
// Shared types and constants for the multicycle MIPS main controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mc_control_fsm_pkg;

    // 4-bit state encoding. HALT has no code of its own because all 16 codes are in use.
    // It is ST_ILLEGAL with the controller's sticky halted flag set (see mc_control_fsm).
    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXEC    = 4'd6,
        ST_ALUWB   = 4'd7,
        ST_IEXEC   = 4'd8,
        ST_IWB     = 4'd9,
        ST_BRANCH  = 4'd10,
        ST_JUMP    = 4'd11,
        ST_JAL1    = 4'd12,
        ST_JAL2    = 4'd13,
        ST_JR      = 4'd14,
        ST_ILLEGAL = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_NE   = 4'd11;

    localparam logic [2:0] SRCB_B      = 3'b000;
    localparam logic [2:0] SRCB_FOUR   = 3'b001;
    localparam logic [2:0] SRCB_IMM    = 3'b010;
    localparam logic [2:0] SRCB_IMMSH2 = 3'b011;
    localparam logic [2:0] SRCB_ZERO   = 3'b100;

    // Every datapath control bundled so the decoder can default it in one assignment.
    typedef struct packed {
        logic       iord;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic [3:0] alu_op;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       branch_ctrl;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_alu_decode.sv
// ALU opcode decode from funct (R-type) and opcode (I-type/branch); flags unknown funct.
// Latency: purely combinational.
// Backpressure: none.
module mc_alu_decode
    import mc_control_fsm_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [3:0] funct_aluop_o,
    output logic       funct_legal_o,
    output logic [3:0] opc_aluop_o
);

    always_comb begin
        funct_aluop_o = ALU_ADD;
        funct_legal_o = 1'b1;
        case (funct_i)
            6'h20, 6'h21: funct_aluop_o = ALU_ADD;
            6'h22, 6'h23: funct_aluop_o = ALU_SUB;
            6'h24:        funct_aluop_o = ALU_AND;
            6'h25:        funct_aluop_o = ALU_OR;
            6'h26:        funct_aluop_o = ALU_XOR;
            6'h27:        funct_aluop_o = ALU_NOR;
            6'h2A:        funct_aluop_o = ALU_SLT;
            6'h2B:        funct_aluop_o = ALU_SLTU;
            default:      funct_legal_o = 1'b0;
        endcase
    end

    // Used in IEXEC (addi/slti) and BRANCH (beq/bne); other opcodes never reach those states.
    always_comb begin
        opc_aluop_o = ALU_ADD;
        case (opcode_i)
            OP_SLTI: opc_aluop_o = ALU_SLT;
            OP_BEQ:  opc_aluop_o = ALU_SUB;
            OP_BNE:  opc_aluop_o = ALU_NE;
            default: opc_aluop_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/mem/write-back, drives all datapath controls.
// Latency: lw 5, sw/R/addi/slti/jal 4, beq/bne/j/jr 3 enabled cycles; outputs are Moore (AluOp also from IR).
// Backpressure: state advances only when clk_en=1; with MC_CTRL_MEM_WAIT_EN, memory states also wait on mem_ready.
//
// Ports: clk_100M/rst (sync, active-high), clk_en, instruction (IR), mem_ready (MC_CTRL_MEM_WAIT_EN only),
//        datapath selects IorD/AluSrcA/AluSrcB/PCSrc/MemtoReg/RegDst/AluOp, write enables IRWrite/PCWrite/
//        RegWrite/MemWrite, Branch/BranchCtrl, illegal_instr pulse, state_o debug state.
// Parameter ILLEGAL_TRAP: 0 returns to FETCH after an illegal instruction, 1 halts until reset.
// Macro MC_CTRL_MEM_WAIT_EN: adds mem_ready handshake on FETCH/MEMRD/MEMWR.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int ILLEGAL_TRAP = 0
) (
    input  logic        clk_100M,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [31:0] instruction,
`ifdef MC_CTRL_MEM_WAIT_EN
    input  logic        mem_ready,
`endif
    output logic        IorD,
    output logic        AluSrcA,
    output logic [2:0]  AluSrcB,
    output logic [1:0]  PCSrc,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  RegDst,
    output logic [3:0]  AluOp,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        Branch,
    output logic        BranchCtrl,
    output logic        illegal_instr,
    output logic [3:0]  state_o
);

    state_e     state_q, state_d;
    logic       halted_q, halted_d;
    ctrl_t      ctl, out;
    logic       mem_ok;
    logic [5:0] opcode, funct;
    logic [3:0] funct_aluop, opc_aluop;
    logic       funct_legal;
    logic       unused_instr;

    assign opcode       = instruction[31:26];
    assign funct        = instruction[5:0];
    assign unused_instr = ^instruction[25:6];

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    mc_alu_decode u_alu_decode (
        .opcode_i      (opcode),
        .funct_i       (funct),
        .funct_aluop_o (funct_aluop),
        .funct_legal_o (funct_legal),
        .opc_aluop_o   (opc_aluop)
    );

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            halted_q <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        ctl      = '0;
        case (state_q)
            ST_FETCH: begin
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = ALU_ADD;
                ctl.ir_write  = 1'b1;
                ctl.pc_write  = 1'b1;
                if (mem_ok) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // Branch target is computed speculatively into AluOut here.
                ctl.alu_src_b = SRCB_IMMSH2;
                ctl.alu_op    = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW:     state_d = ST_MEMADR;
                    OP_RTYPE:         state_d = (funct == FN_JR) ? ST_JR : ST_EXEC;
                    OP_ADDI, OP_SLTI: state_d = ST_IEXEC;
                    OP_BEQ, OP_BNE:   state_d = ST_BRANCH;
                    OP_J:             state_d = ST_JUMP;
                    OP_JAL:           state_d = ST_JAL1;
                    default:          state_d = ST_ILLEGAL;
                endcase
            end
            ST_MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALU_ADD;
                state_d       = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                ctl.iord = 1'b1;
                if (mem_ok) state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                ctl.mem_to_reg = 2'b01;
                ctl.reg_write  = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_MEMWR: begin
                ctl.iord      = 1'b1;
                ctl.mem_write = 1'b1;
                if (mem_ok) state_d = ST_FETCH;
            end
            ST_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_op    = funct_aluop;
                state_d       = funct_legal ? ST_ALUWB : ST_ILLEGAL;
            end
            ST_ALUWB: begin
                ctl.reg_dst   = 2'b01;
                ctl.reg_write = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_IEXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = opc_aluop;
                state_d       = ST_IWB;
            end
            ST_IWB: begin
                ctl.reg_write = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_BRANCH: begin
                ctl.alu_src_a   = 1'b1;
                ctl.alu_src_b   = SRCB_B;
                ctl.alu_op      = opc_aluop;
                ctl.branch      = 1'b1;
                ctl.branch_ctrl = (opcode == OP_BNE);
                ctl.pc_src      = 2'b01;
                state_d         = ST_FETCH;
            end
            ST_JUMP: begin
                ctl.pc_src   = 2'b10;
                ctl.pc_write = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_JAL1: begin
                // A + 0 with A selecting PC latches PC+4 into AluOut for the link write.
                ctl.alu_src_b = SRCB_ZERO;
                ctl.alu_op    = ALU_ADD;
                state_d       = ST_JAL2;
            end
            ST_JAL2: begin
                ctl.reg_dst    = 2'b10;
                ctl.mem_to_reg = 2'b10;
                ctl.reg_write  = 1'b1;
                ctl.pc_src     = 2'b10;
                ctl.pc_write   = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_JR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_ZERO;
                ctl.alu_op    = ALU_ADD;
                ctl.pc_write  = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_ILLEGAL: begin
                // Halted flag turns this state into the trap HALT: outputs stay 0 until reset.
                if (!halted_q) begin
                    ctl.illegal = 1'b1;
                    if (ILLEGAL_TRAP != 0) halted_d = 1'b1;
                    else                   state_d  = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Write enables wait for memory; reset forces everything quiet so an abandoned instruction writes nothing.
    always_comb begin
        out           = ctl;
        out.ir_write  = ctl.ir_write  & mem_ok;
        out.pc_write  = ctl.pc_write  & mem_ok;
        out.mem_write = ctl.mem_write & mem_ok;
        if (rst) out = '0;
    end

    assign IorD          = out.iord;
    assign AluSrcA       = out.alu_src_a;
    assign AluSrcB       = out.alu_src_b;
    assign PCSrc         = out.pc_src;
    assign MemtoReg      = out.mem_to_reg;
    assign RegDst        = out.reg_dst;
    assign AluOp         = out.alu_op;
    assign IRWrite       = out.ir_write;
    assign PCWrite       = out.pc_write;
    assign RegWrite      = out.reg_write;
    assign MemWrite      = out.mem_write;
    assign Branch        = out.branch;
    assign BranchCtrl    = out.branch_ctrl;
    assign illegal_instr = out.illegal;
    assign state_o       = rst ? 4'd0 : state_q;

endmodule
